// File: rtl/nios_sysid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_sysid_pkg
//  Description : Register map, control bit and cycle type for the sysid slave
//  Revision    : 1.0  initial release
// ============================================================================
package nios_sysid_pkg;

    localparam logic [31:0] REG_ID        = 32'd0;
    localparam logic [31:0] REG_TIMESTAMP = 32'd1;
    localparam logic [31:0] REG_UPTIME_LO = 32'd2;
    localparam logic [31:0] REG_UPTIME_HI = 32'd3;
    localparam logic [31:0] REG_SECONDS   = 32'd4;
    localparam logic [31:0] REG_SCRATCH   = 32'd5;
    localparam logic [31:0] REG_CONTROL   = 32'd6;
    localparam logic [31:0] REG_RESERVED  = 32'd7;
    localparam logic [31:0] REG_USER_BASE = 32'd8;

    localparam int CTRL_CLEAR_BIT = 0;

    typedef logic [63:0] cycle_t;

endpackage : nios_sysid_pkg
`default_nettype wire

// File: rtl/nios_system_sysid_uptime.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_sysid_uptime
//  Description : 64-bit free-running cycle counter plus prescaled seconds count
//  Revision    : 1.0  initial release
// ============================================================================
module nios_system_sysid_uptime
    import nios_sysid_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    output cycle_t       cycle,
    output logic [31:0]  seconds
);

    localparam int          c_PRESC_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(CLK_HZ - 1);

    cycle_t                 r_cycle;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [31:0]            r_seconds;

    // Clear shares the reset path so it always wins over a terminal count.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_cycle   <= '0;
            r_presc   <= '0;
            r_seconds <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (r_presc == c_PRESC_LAST) begin
                r_presc   <= '0;
                r_seconds <= r_seconds + 32'd1;
            end else begin
                r_presc   <= r_presc + c_PRESC_W'(1);
            end
        end
    end

    assign cycle   = r_cycle;
    assign seconds = r_seconds;

endmodule : nios_system_sysid_uptime
`default_nettype wire

// File: rtl/nios_system_sysid_ext.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_sysid_ext
//  Description : Avalon-MM system-ID, uptime and scratch slave (read latency 1)
//  Revision    : 1.0  initial release
// ============================================================================
module nios_system_sysid_ext
    import nios_sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter int          CLK_HZ    = 50_000_000,
    parameter int          ADDR_W    = 4,
    parameter int          N_USER    = 4,
    parameter logic [32*((N_USER > 0) ? N_USER : 1)-1:0] USER_INIT = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [31:0]  w_addr;
    logic         w_rd;
    logic         w_wr;
    logic         w_clear;
    logic [31:0]  w_rdata;
    cycle_t       w_cycle;
    logic [31:0]  w_seconds;

    logic [31:0]  r_hi_shadow;
    logic [31:0]  r_scratch;
    logic [31:0]  r_readdata;
    logic         r_readdatavalid;

    assign w_addr  = 32'(address);
    // A simultaneous read and write performs only the write.
    assign w_wr    = write;
    assign w_rd    = read & ~write;
    assign w_clear = w_wr && (w_addr == REG_CONTROL) && writedata[CTRL_CLEAR_BIT];

    nios_system_sysid_uptime #(
        .CLK_HZ (CLK_HZ)
    ) u_uptime (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_clear),
        .cycle   (w_cycle),
        .seconds (w_seconds)
    );

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            REG_ID:        w_rdata = ID_VALUE;
            REG_TIMESTAMP: w_rdata = TIMESTAMP;
            REG_UPTIME_LO: w_rdata = w_cycle[31:0];
            REG_UPTIME_HI: w_rdata = r_hi_shadow;
            REG_SECONDS:   w_rdata = w_seconds;
            REG_SCRATCH:   w_rdata = r_scratch;
            default: begin
                for (int k = 0; k < N_USER; k++) begin
                    if (w_addr == REG_USER_BASE + 32'(k)) begin
                        w_rdata = USER_INIT[32*k +: 32];
                    end
                end
            end
        endcase
    end

    // The LO read captures the matching upper half so a later HI read is coherent.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi_shadow     <= '0;
            r_scratch       <= '0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            r_readdatavalid <= w_rd;
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
            if (w_rd && (w_addr == REG_UPTIME_LO)) begin
                r_hi_shadow <= w_cycle[63:32];
            end
            if (w_wr && (w_addr == REG_SCRATCH)) begin
                r_scratch <= writedata;
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_readdatavalid;

endmodule : nios_system_sysid_ext
`default_nettype wire
